// File: rtl/ldmac_pkg.sv
// ---------------------------------------------------------------------------
// ldmac_pkg
// Shared definitions for the bitsliced S-box blocks.
//   state_t   : controller state encoding (IDLE, RUN, DONE)
//   NUM_COLS  : number of 4-bit columns in one state (16)
//   PLANE_W   : width of one bitsliced plane a0..a3 / b0..b3 (16)
// ---------------------------------------------------------------------------
package ldmac_pkg;

    localparam int NUM_COLS = 16;
    localparam int PLANE_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gs_inv.sv
// ---------------------------------------------------------------------------
// gs_inv
// Combinational inverse of the forward 4-bit GS S-box.
//   x         : input  [3:0]  S-box output value to be inverted
//   sbox_type : input         0 = inverse of the PRESENT-style GS box,
//                             1 = inverse of the GIFT-style GS box
//   y         : output [3:0]  GS(sbox_type)^-1 (x)
// Forward boxes (index 0..F):
//   type 0 : C 5 6 B 9 0 A D 3 E F 8 4 7 1 2
//   type 1 : 1 A 4 C 6 F 3 9 2 D B 7 5 0 8 E
// ---------------------------------------------------------------------------
module gs_inv (
    input  logic [3:0] x,
    input  logic       sbox_type,
    output logic [3:0] y
);

    logic [3:0] inv0;
    logic [3:0] inv1;

    always_comb begin
        inv0 = 4'h0;
        case (x)
            4'h0: inv0 = 4'h5;  4'h1: inv0 = 4'hE;  4'h2: inv0 = 4'hF;  4'h3: inv0 = 4'h8;
            4'h4: inv0 = 4'hC;  4'h5: inv0 = 4'h1;  4'h6: inv0 = 4'h2;  4'h7: inv0 = 4'hD;
            4'h8: inv0 = 4'hB;  4'h9: inv0 = 4'h4;  4'hA: inv0 = 4'h6;  4'hB: inv0 = 4'h3;
            4'hC: inv0 = 4'h0;  4'hD: inv0 = 4'h7;  4'hE: inv0 = 4'h9;  4'hF: inv0 = 4'hA;
            default: inv0 = 4'h0;
        endcase
    end

    always_comb begin
        inv1 = 4'h0;
        case (x)
            4'h0: inv1 = 4'hD;  4'h1: inv1 = 4'h0;  4'h2: inv1 = 4'h8;  4'h3: inv1 = 4'h6;
            4'h4: inv1 = 4'h2;  4'h5: inv1 = 4'hC;  4'h6: inv1 = 4'h4;  4'h7: inv1 = 4'hB;
            4'h8: inv1 = 4'hE;  4'h9: inv1 = 4'h7;  4'hA: inv1 = 4'h1;  4'hB: inv1 = 4'hA;
            4'hC: inv1 = 4'h3;  4'hD: inv1 = 4'h9;  4'hE: inv1 = 4'hF;  4'hF: inv1 = 4'h5;
            default: inv1 = 4'h0;
        endcase
    end

    assign y = sbox_type ? inv1 : inv0;

endmodule

// File: rtl/inv_sub_cells_serial.sv
// ---------------------------------------------------------------------------
// inv_sub_cells_serial
// Serial inverse SubCells over a 16-column bitsliced state. COLS_PER_CYCLE
// columns (1, 2, 4, 8 or 16) are inverted per clock, column 0 upward.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the offering side holds its data until then, and ready never
// depends on valid.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready only in IDLE)
//   a0..a3               : bitsliced input, column i = {a3[i],a2[i],a1[i],a0[i]}
//   sbox_type            : GS box selector, captured with the input
//   out_valid / out_ready: output handshake (out_valid only in DONE)
//   b0..b3               : bitsliced result, same layout as a0..a3
//   busy                 : high whenever the controller is not in IDLE
// ---------------------------------------------------------------------------
module inv_sub_cells_serial
    import ldmac_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PLANE_W-1:0] a0,
    input  logic [PLANE_W-1:0] a1,
    input  logic [PLANE_W-1:0] a2,
    input  logic [PLANE_W-1:0] a3,
    input  logic               sbox_type,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PLANE_W-1:0] b0,
    output logic [PLANE_W-1:0] b1,
    output logic [PLANE_W-1:0] b2,
    output logic [PLANE_W-1:0] b3,
    output logic               busy
);

    // STEP wraps to 0 for 16 columns per cycle; the counter then stays at 0,
    // which is also the last (and only) RUN position.
    localparam logic [3:0] STEP     = 4'(COLS_PER_CYCLE);
    localparam logic [3:0] LAST_CNT = 4'(NUM_COLS - COLS_PER_CYCLE);

    state_t             state;
    logic [3:0]         cnt;
    logic               sbox_q;
    logic [PLANE_W-1:0] w     [4];
    logic [PLANE_W-1:0] w_nxt [4];

    logic [3:0] col_idx [COLS_PER_CYCLE];
    logic [3:0] col_in  [COLS_PER_CYCLE];
    logic [3:0] col_out [COLS_PER_CYCLE];

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        // cnt is always a multiple of COLS_PER_CYCLE, so cnt + k never wraps.
        assign col_idx[k] = cnt + 4'(k);
        assign col_in[k]  = {w[3][col_idx[k]], w[2][col_idx[k]],
                             w[1][col_idx[k]], w[0][col_idx[k]]};

        gs_inv u_gs_inv (
            .x         (col_in[k]),
            .sbox_type (sbox_q),
            .y         (col_out[k])
        );
    end

    // Working registers with the current group of columns substituted.
    always_comb begin
        w_nxt = w;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            for (int p = 0; p < 4; p++) begin
                w_nxt[p][col_idx[k]] = col_out[k][p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            sbox_q <= 1'b0;
            w      <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        w[0]   <= a0;
                        w[1]   <= a1;
                        w[2]   <= a2;
                        w[3]   <= a3;
                        sbox_q <= sbox_type;
                        cnt    <= 4'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    w <= w_nxt;
                    if (cnt == LAST_CNT) begin
                        cnt   <= 4'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated with rst_n so nothing is offered while reset is held.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign b0 = w[0];
    assign b1 = w[1];
    assign b2 = w[2];
    assign b3 = w[3];

endmodule

// File: tb/tb_inv_sub_cells_serial.sv
// ---------------------------------------------------------------------------
// tb_inv_sub_cells_serial
// Five instances (COLS_PER_CYCLE = 1, 2, 4, 8, 16) share one set of inputs
// and out_ready. Vectors are applied from a table; results, latency and RUN
// length of every instance are compared against bench-computed values.
// ---------------------------------------------------------------------------
module tb_inv_sub_cells_serial;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        sbox_type = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;

    logic [NI-1:0] in_ready_v, out_valid_v, busy_v;
    logic [15:0]   b0_v [NI];
    logic [15:0]   b1_v [NI];
    logic [15:0]   b2_v [NI];
    logic [15:0]   b3_v [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        inv_sub_cells_serial #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .a0        (a0),
            .a1        (a1),
            .a2        (a2),
            .a3        (a3),
            .sbox_type (sbox_type),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .b0        (b0_v[g]),
            .b1        (b1_v[g]),
            .b2        (b2_v[g]),
            .b3        (b3_v[g]),
            .busy      (busy_v[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int lat     [NI];
    int run_cyc [NI];

    typedef struct {
        logic [63:0] a;    // {a3,a2,a1,a0}
        logic        st;
        logic [63:0] exp;  // {b3,b2,b1,b0}
    } vec_t;
    vec_t vecs [37];

    // ---------------- reference model: forward GS SubCells ----------------
    function automatic logic [3:0] fwd_sbox(input logic st, input logic [3:0] x);
        logic [63:0] tbl;
        tbl = st ? 64'hE8057BD293F6C4A1 : 64'h21748FE3DA09B65C;
        return tbl[x*4 +: 4];
    endfunction

    function automatic logic [63:0] sub_cells(input logic [63:0] p, input logic st);
        logic [63:0] r;
        logic [3:0]  c;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            c = fwd_sbox(st, {p[48+i], p[32+i], p[16+i], p[i]});
            r[i]    = c[0];
            r[16+i] = c[1];
            r[32+i] = c[2];
            r[48+i] = c[3];
        end
        return r;
    endfunction

    function automatic logic [63:0] outs(input int g);
        return {b3_v[g], b2_v[g], b1_v[g], b0_v[g]};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // ---------------- drivers ----------------
    task automatic wait_ready(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(&in_ready_v) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!(&in_ready_v)) timeout_fail({name, "_ready"});
    endtask

    // Offers one state, then watches all instances until each holds a result.
    // out_ready stays low, so finished instances wait in DONE.
    task automatic run_op(input logic [63:0] a, input logic st, input bit toggle,
                          input string name);
        int k;
        bit all_done;
        wait_ready(name);
        {a3, a2, a1, a0} = a;
        sbox_type = st;
        in_valid  = 1'b1;
        for (int g = 0; g < NI; g++) begin
            lat[g] = 0;
            run_cyc[g] = 0;
        end
        k = 0;
        all_done = 1'b0;
        while (!all_done && k < 60) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (toggle) begin
                {a3, a2, a1, a0} = {$urandom, $urandom};
                sbox_type = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            for (int g = 0; g < NI; g++) begin
                if (out_valid_v[g] && lat[g] == 0) lat[g] = k;
                if (busy_v[g] && !out_valid_v[g]) run_cyc[g]++;
            end
            all_done = &out_valid_v;
        end
        in_valid = 1'b0;
        if (!all_done) timeout_fail({name, "_done"});
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s_c%0d_latency", name, 1 << g), 64'(lat[g]), 64'(16 / (1 << g) + 1));
            chk($sformatf("%s_c%0d_run", name, 1 << g), 64'(run_cyc[g]), 64'(16 >> g));
        end
    endtask

    task automatic check_result(input logic [63:0] exp, input string name);
        for (int g = 0; g < NI; g++)
            chk($sformatf("%s_c%0d_data", name, 1 << g), outs(g), exp);
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_idle"}, 64'({in_ready_v, out_valid_v}), 64'({5'h1f, 5'h00}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        logic [3:0]  v;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", 64'({in_ready_v, out_valid_v, busy_v}), 64'h0);
        for (int g = 0; g < NI; g++) chk($sformatf("reset_c%0d_data", 1 << g), outs(g), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release_ready", 64'(in_ready_v), 64'h1f);

        // ---------------- vector table ----------------
        // Hand-computed direct inverses (all columns equal).
        vecs[0] = '{a: 64'h0, st: 1'b0, exp: 64'h0000_FFFF_0000_FFFF};               // inv0(0)=5
        vecs[1] = '{a: 64'h0, st: 1'b1, exp: 64'hFFFF_FFFF_0000_FFFF};               // inv1(0)=D
        vecs[2] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, st: 1'b0, exp: 64'hFFFF_0000_FFFF_0000}; // inv0(F)=A
        vecs[3] = '{a: 64'h0000_0000_0000_FFFF, st: 1'b1, exp: 64'h0};               // inv1(1)=0
        // Round trip of the reference state.
        p = 64'h1234_5678_9ABC_DEF0;
        vecs[4] = '{a: sub_cells(p, 1'b0), st: 1'b0, exp: p};
        // Every column value, both boxes, all columns carrying the same value.
        for (int i = 0; i < 32; i++) begin
            v = 4'(i % 16);
            p = {{16{v[3]}}, {16{v[2]}}, {16{v[1]}}, {16{v[0]}}};
            vecs[5 + i] = '{a: sub_cells(p, 1'(i / 16)), st: 1'(i / 16), exp: p};
        end

        for (int i = 0; i < 37; i++) begin
            run_op(vecs[i].a, vecs[i].st, 1'b0, $sformatf("vec%0d", i));
            check_result(vecs[i].exp, $sformatf("vec%0d", i));
            finish_op($sformatf("vec%0d", i));
        end

        // ---------------- backpressure ----------------
        p = 64'hA5C3_0F96_7E18_B24D;
        run_op(sub_cells(p, 1'b1), 1'b1, 1'b0, "bp");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_flags", c), 64'({in_ready_v, out_valid_v}), 64'({5'h00, 5'h1f}));
            check_result(p, $sformatf("bp_hold%0d", c));
        end
        finish_op("bp");

        // ---------------- inputs toggling during RUN ----------------
        p = 64'h0123_4567_89AB_CDEF;
        run_op(sub_cells(p, 1'b1), 1'b1, 1'b1, "toggle");
        check_result(p, "toggle");
        finish_op("toggle");

        // ---------------- reset in the second RUN cycle ----------------
        p = 64'hFEDC_BA98_7654_3210;
        wait_ready("rst_mid");
        {a3, a2, a1, a0} = sub_cells(p, 1'b0);
        sbox_type = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);          // handshake
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);          // start of second RUN cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", 64'({in_ready_v, out_valid_v, busy_v}), 64'h0);
        for (int g = 0; g < NI; g++) chk($sformatf("rst_mid_c%0d_data", 1 << g), outs(g), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_release_ready", 64'(in_ready_v), 64'h1f);
        p = 64'h3C3C_5A5A_0FF0_9669;
        run_op(sub_cells(p, 1'b0), 1'b0, 1'b0, "after_rst");
        check_result(p, "after_rst");
        finish_op("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inv_sub_cells_serial.md
INV_SUB_CELLS_SERIAL -- requirements
Module: inv_sub_cells_serial

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 4, meaning the number of 4-bit columns inverse-substituted per clock; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input state offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an input state.
REQ-006 SHALL have ports a0, a1, a2, a3  input  16 each  bitsliced input state; bit i of a3..a0 forms column i (a3 = MSB).
REQ-007 SHALL have port sbox_type  input  1  selects which of the two forward GS S-boxes is inverted; sampled with the input.
REQ-008 SHALL have port out_valid  output  1  result is held on b0..b3.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have ports b0, b1, b2, b3  output  16 each  bitsliced result, same column layout as a0..a3.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL compute, per column i, the 4-bit inverse GS(sbox_type)^-1 such that feeding the forward SubCells output with the same sbox_type back in returns the original a0..a3 exactly.
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 SHALL assert in_ready only in IDLE.
REQ-015 SHALL, on in_valid & in_ready, register a0..a3 and sbox_type, clear the column counter to 0 and enter RUN.
REQ-016 SHALL, in RUN, each cycle replace columns [cnt .. cnt+COLS_PER_CYCLE-1] of the working registers with their inverse S-box values and advance cnt by COLS_PER_CYCLE, processing from column 0 upward.
REQ-017 SHALL leave RUN for DONE in the cycle that processes column 15; RUN therefore lasts exactly 16/COLS_PER_CYCLE cycles.
REQ-018 SHALL assert out_valid only in DONE, with b0..b3 driven from the working registers and held stable until out_valid & out_ready.
REQ-019 SHALL return to IDLE on out_valid & out_ready; with out_ready held high, the input handshake to first out_valid takes 16/COLS_PER_CYCLE + 1 cycles.
REQ-020 SHALL ignore a0..a3, sbox_type and in_valid outside IDLE; changes to these inputs SHALL NOT affect an operation in progress.
REQ-021 SHALL hold DONE indefinitely while out_ready is low (backpressure), with no loss or alteration of the result.
REQ-022 SHALL size the column counter at 4 bits and never let it exceed 15 while in RUN.
REQ-023 SHALL, for COLS_PER_CYCLE = 16, spend exactly one cycle in RUN.

Reset
REQ-024 SHALL, on rst_n low at any time (including mid-RUN or in DONE), immediately force IDLE, cnt = 0, working registers = 0 and captured sbox_type = 0, and abandon the operation in progress.
REQ-025 SHALL, during reset, drive in_ready = 0, out_valid = 0, busy = 0 and b0..b3 = 16'h0000.
REQ-026 SHALL drive in_ready = 1 on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL take the state-type enumeration (IDLE, RUN, DONE), NUM_COLS = 16 and PLANE_W = 16 from the shared package ldmac_pkg.
REQ-028 SHALL instantiate COLS_PER_CYCLE copies of the combinational sub-module gs_inv: inputs 4 bits plus sbox_type, output 4 bits, the exact inverse of GS.
REQ-029 SHALL contain no other sub-modules, and no storage beyond the state, counter, captured sbox_type and the four working registers.

Verification
REQ-030 SHALL check a round trip: a3..a0 = 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, passed through forward SubCells with sbox_type = 0 and then into this block with sbox_type = 0 -> b3..b0 = 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0.
REQ-031 SHALL check all 16 column values for both sbox_type settings, with every column carrying the same value: forward-then-inverse returns the value, and out_valid rises exactly 5 cycles after the input handshake at COLS_PER_CYCLE = 4.
REQ-032 SHALL check backpressure: out_ready held low for 10 cycles -> out_valid stays 1, b0..b3 stay stable, in_ready stays 0; then out_ready = 1 -> IDLE on the next cycle.
REQ-033 SHALL check input toggling during RUN: a0..a3 and sbox_type toggled every cycle -> result equals the inverse of the state captured at the handshake.
REQ-034 SHALL check reset mid-RUN: rst_n pulsed low at the second RUN cycle -> out_valid = 0, b0..b3 = 0, then in_ready = 1 after release, and a following operation completes correctly.
REQ-035 SHALL check all COLS_PER_CYCLE values {1, 2, 4, 8, 16} -> identical results, with RUN lasting 16, 8, 4, 2 and 1 cycles respectively.
